// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: controller state encoding and frame length.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RECV  = 2'd2,
        ST_STORE = 2'd3
    } rx_state_t;

    // start + 8 data + stop
    localparam int FRAME_BITS_DEF = 10;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous receive FIFO; storage is not reset, only pointers and occupancy.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          din,
    input  logic                       pop,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive controller around uart_rx: baud tick generation, frame tracking with
// stop-bit and timeout checks, and buffering of received bytes for the host.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DIV_W         = 16,
    parameter int FRAME_BITS    = FRAME_BITS_DEF,
    parameter int FIFO_DEPTH    = 4,
    parameter int TIMEOUT_TICKS = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_en,
    input  logic [DIV_W-1:0]              baud_div,
    output logic                          baud_uart,
    output logic                          enable_rx,
    input  logic                          rxd,
    input  logic [7:0]                    r_data,
    input  logic                          sampling,
    output logic [7:0]                    dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          frame_err,
    output logic                          timeout_err,
    input  logic                          clr_err
);

    localparam int BC_W = $clog2(FRAME_BITS + 1);
    localparam int TC_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_BITS - 1);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT_TICKS - 1);

    rx_state_t        state;
    logic [DIV_W-1:0] baud_cnt;
    logic [BC_W-1:0]  bit_cnt;
    logic [TC_W-1:0]  tick_cnt;
    logic             stop_bit;
    logic             in_store;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;

    // Compare with >= so a divisor lowered mid-count still wraps immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt  <= '0;
            baud_uart <= 1'b0;
        end else if (!enable_rx) begin
            baud_cnt  <= '0;
            baud_uart <= 1'b0;
        end else if (baud_cnt >= baud_div) begin
            baud_cnt  <= '0;
            baud_uart <= 1'b1;
        end else begin
            baud_cnt  <= baud_cnt + 1'b1;
            baud_uart <= 1'b0;
        end
    end

    assign in_store  = (state == ST_STORE);
    assign fifo_pop  = dout_valid & dout_ready;
    assign fifo_push = in_store & stop_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            enable_rx   <= 1'b0;
            bit_cnt     <= '0;
            tick_cnt    <= '0;
            stop_bit    <= 1'b0;
            overrun     <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Clear first so any set event later in this block takes priority.
            if (clr_err) begin
                overrun     <= 1'b0;
                frame_err   <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (in_store && !stop_bit) frame_err <= 1'b1;
            if (in_store && stop_bit && fifo_full && !fifo_pop) overrun <= 1'b1;

            if (!rx_en) begin
                state     <= ST_IDLE;
                enable_rx <= 1'b0;
                bit_cnt   <= '0;
                tick_cnt  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state     <= ST_ARM;
                        enable_rx <= 1'b1;
                        bit_cnt   <= '0;
                    end
                    ST_ARM: begin
                        enable_rx <= 1'b1;
                        tick_cnt  <= '0;
                        if (sampling) begin
                            bit_cnt <= BC_W'(1);
                            state   <= ST_RECV;
                        end else begin
                            bit_cnt <= '0;
                        end
                    end
                    ST_RECV: begin
                        if (sampling) begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            tick_cnt <= '0;
                            if (bit_cnt == BC_LAST) begin
                                state    <= ST_STORE;
                                stop_bit <= rxd;
                            end
                        end else if (baud_uart) begin
                            if (tick_cnt == TC_LAST) begin
                                // Drop enable_rx for one cycle so uart_rx resynchronises.
                                timeout_err <= 1'b1;
                                state       <= ST_ARM;
                                enable_rx   <= 1'b0;
                                bit_cnt     <= '0;
                                tick_cnt    <= '0;
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    ST_STORE: begin
                        state   <= ST_ARM;
                        bit_cnt <= '0;
                    end
                    default: begin
                        state     <= ST_IDLE;
                        enable_rx <= 1'b0;
                    end
                endcase
            end
        end
    end

    uart_rx_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (r_data),
        .pop   (fifo_pop),
        .dout  (dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign dout_valid = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: baud timing, frame table, FIFO full/overrun, timeout and reset.
module tb_uart_rx_ctrl;

    localparam int FRAME = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_en;
    logic [15:0] baud_div;
    logic        baud_uart;
    logic        enable_rx;
    logic        rxd;
    logic [7:0]  r_data;
    logic        sampling;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [2:0]  fifo_count;
    logic        overrun;
    logic        frame_err;
    logic        timeout_err;
    logic        clr_err;

    int tests = 0;
    int fails = 0;

    uart_rx_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .rx_en       (rx_en),
        .baud_div    (baud_div),
        .baud_uart   (baud_uart),
        .enable_rx   (enable_rx),
        .rxd         (rxd),
        .r_data      (r_data),
        .sampling    (sampling),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .fifo_count  (fifo_count),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       pop_first;
        logic [7:0] exp_pop;
        logic [7:0] data;
        logic       stop;
        logic [2:0] exp_cnt;
        logic       exp_ferr;
        logic       exp_ovr;
        logic [7:0] exp_head;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // n sampling pulses separated by one idle cycle; on a full frame the idle
    // cycle after the last pulse is the STORE cycle and may carry a pop.
    task automatic pulses(input int n, input logic [7:0] d, input logic last_rxd,
                          input logic pop_at_store);
        for (int i = 1; i <= n; i++) begin
            r_data   = d;
            rxd      = (i == FRAME) ? last_rxd : 1'b1;
            sampling = 1'b1;
            tick();
            sampling = 1'b0;
            rxd      = 1'b1;
            if (i == FRAME) dout_ready = pop_at_store;
            tick();
            dout_ready = 1'b0;
        end
    endtask

    task automatic pop_chk(input string nm, input logic [7:0] exp);
        chk(nm, dout, exp);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
    endtask

    task automatic baud_pattern(input string nm);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk(nm, baud_uart, (i >= 6 && (i % 5) == 1) ? 1 : 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{1'b0, 1'b0, 8'h00, 8'hA5, 1'b1, 3'd1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 3'd1, 1'b1, 1'b0, 8'hA5};
        vecs[2] = '{1'b1, 1'b1, 8'hA5, 8'h01, 1'b1, 3'd1, 1'b0, 1'b0, 8'h01};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 3'd2, 1'b0, 1'b0, 8'h01};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 8'h03, 1'b1, 3'd3, 1'b0, 1'b0, 8'h01};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 8'h04, 1'b1, 3'd4, 1'b0, 1'b0, 8'h01};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h05, 1'b1, 3'd4, 1'b0, 1'b1, 8'h01};

        rst = 1'b1; rx_en = 1'b0; baud_div = 16'd4; rxd = 1'b1; r_data = 8'h00;
        sampling = 1'b0; dout_ready = 1'b0; clr_err = 1'b0;
        tick(); tick();
        chk("rst_baud", baud_uart, 0);
        chk("rst_en", enable_rx, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_flags", {overrun, frame_err, timeout_err}, 0);
        rst = 1'b0;
        tick();

        rx_en = 1'b1;
        baud_pattern("baud_div4");
        tick(); tick();
        rx_en = 1'b0;
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("baud_off", baud_uart, 0);
        end
        rx_en = 1'b1;
        baud_pattern("baud_restart");

        rx_en = 1'b0;
        tick(); tick();
        baud_div = 16'd0;
        rx_en = 1'b1;
        tick();
        chk("baud0_first", baud_uart, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("baud0_every", baud_uart, 1);
        end

        rx_en = 1'b0;
        tick(); tick();
        baud_div = 16'd100;
        rx_en = 1'b1;
        tick(); tick();

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].clr) begin
                clr_err = 1'b1;
                tick();
                clr_err = 1'b0;
                chk("vec_clr", frame_err, 0);
            end
            if (vecs[v].pop_first) pop_chk("vec_pop", vecs[v].exp_pop);
            pulses(FRAME, vecs[v].data, vecs[v].stop, 1'b0);
            chk("vec_count", fifo_count, vecs[v].exp_cnt);
            chk("vec_ferr", frame_err, vecs[v].exp_ferr);
            chk("vec_ovr", overrun, vecs[v].exp_ovr);
            chk("vec_valid", dout_valid, 1);
            chk("vec_head", dout, vecs[v].exp_head);
        end

        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_ovr", overrun, 0);
        pulses(FRAME, 8'h06, 1'b1, 1'b1);
        chk("full_pp_count", fifo_count, 4);
        chk("full_pp_ovr", overrun, 0);
        pop_chk("full_pp_pop0", 8'h02);
        pop_chk("full_pp_pop1", 8'h03);
        pop_chk("full_pp_pop2", 8'h04);
        pop_chk("full_pp_pop3", 8'h06);
        chk("drain_count", fifo_count, 0);
        chk("drain_valid", dout_valid, 0);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        chk("empty_pop", fifo_count, 0);

        pulses(FRAME, 8'h11, 1'b1, 1'b0);
        pulses(4, 8'h22, 1'b1, 1'b0);
        rx_en = 1'b0;
        tick();
        chk("abort_en", enable_rx, 0);
        chk("abort_keep", fifo_count, 1);
        tick();
        rx_en = 1'b1;
        tick(); tick();
        pulses(FRAME, 8'h77, 1'b1, 1'b0);
        chk("after_abort_count", fifo_count, 2);
        pop_chk("after_abort_pop0", 8'h11);
        pop_chk("after_abort_pop1", 8'h77);

        baud_div = 16'd0;
        tick(); tick();
        clr_err = 1'b1;
        pulses(2, 8'h33, 1'b1, 1'b0);
        sampling = 1'b1;
        tick();
        sampling = 1'b0;
        n = 0;
        while (enable_rx && n < 100) begin
            tick();
            n++;
        end
        chk("to_ticks", n, 32);
        chk("to_set_wins", timeout_err, 1);
        clr_err = 1'b0;
        tick();
        chk("to_en_back", enable_rx, 1);
        chk("to_sticky", timeout_err, 1);
        chk("to_count", fifo_count, 0);
        pulses(FRAME, 8'h88, 1'b1, 1'b0);
        chk("to_arm_count", fifo_count, 1);
        chk("to_arm_head", dout, 8'h88);

        pulses(4, 8'h44, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_baud", baud_uart, 0);
        chk("mid_rst_en", enable_rx, 0);
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_flags", {overrun, frame_err, timeout_err}, 0);
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
